// File: rtl/natv_arb_pkg.sv
// Shared types and constants for the native-bus round-robin arbiter.
package natv_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] NATV_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/natv_rr_picker.sv
// Combinational round-robin selector: first requester after last_i wins.
module natv_rr_picker
  import natv_arb_pkg::*;
#(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_MST-1:0] win_o,
  output logic [IDX_W-1:0]   win_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    // Scan last+1 .. last+NUM_MST so the previous owner has lowest priority.
    for (int k = 1; k <= NUM_MST; k++) begin
      idx = IDX_W'((int'(last_i) + k) % NUM_MST);
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        win_o[idx] = 1'b1;
        win_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/natv_bus_arbiter.sv
// Round-robin arbiter sharing one native valid/ready bus among NUM_MST masters.
// Optional bus timeout enabled with macro NATV_ARB_TIMEOUT_EN.
module natv_bus_arbiter
  import natv_arb_pkg::*;
#(
  parameter int NUM_MST     = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_MST-1:0]        mst_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0] mst_addr_i,
  input  logic [NUM_MST*DATA_W-1:0] mst_wdata_i,
  input  logic [NUM_MST*STRB_W-1:0] mst_wstrb_i,
  output logic [NUM_MST-1:0]        mst_ready_o,
  output logic [DATA_W-1:0]         mst_rdata_o,
  output logic                      natv_valid_o,
  output logic [ADDR_W-1:0]         natv_addr_o,
  output logic [DATA_W-1:0]         natv_wdata_o,
  output logic [STRB_W-1:0]         natv_wstrb_o,
  input  logic [DATA_W-1:0]         natv_rdata_i,
  input  logic                      natv_ready_i,
  output logic [NUM_MST-1:0]        grant_o,
  output logic                      timeout_o
);

  localparam int IDX_W = $clog2(NUM_MST);

  if (NUM_MST < 2 || NUM_MST > 8 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("natv_bus_arbiter: NUM_MST must be 2..8 and TIMEOUT_CYC at least 2");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_MST-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [NUM_MST-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  logic               gvalid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [STRB_W-1:0]  sel_wstrb;
  logic               tmo_fire;

  natv_rr_picker #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i     (mst_valid_i),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

  always_comb begin
    gvalid    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        gvalid    = mst_valid_i[k];
        sel_addr  = mst_addr_i[ADDR_W*k +: ADDR_W];
        sel_wdata = mst_wdata_i[DATA_W*k +: DATA_W];
        sel_wstrb = mst_wstrb_i[STRB_W*k +: STRB_W];
      end
    end
  end

`ifdef NATV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero in IDLE, so every BUSY entry starts counting from zero.
  assign cnt_d    = (state_q == BUSY) ? cnt_q + CNT_W'(1) : '0;
  assign tmo_fire = (state_q == BUSY) && gvalid && !natv_ready_i &&
                    (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo_fire = 1'b0;
`endif

  assign timeout_o = tmo_fire;
  assign grant_o   = grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    gidx_d       = gidx_q;
    last_d       = last_q;
    mst_ready_o  = '0;
    mst_rdata_o  = '0;
    natv_valid_o = 1'b0;
    natv_addr_o  = '0;
    natv_wdata_o = '0;
    natv_wstrb_o = '0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = BUSY;
          grant_d = win;
          gidx_d  = win_idx;
          last_d  = win_idx;
        end
      end
      BUSY: begin
        natv_valid_o = gvalid;
        natv_addr_o  = sel_addr;
        natv_wdata_o = sel_wdata;
        natv_wstrb_o = sel_wstrb;
        if (!gvalid) begin
          // Owner withdrew its request: abandon without completing.
          state_d = IDLE;
          grant_d = '0;
        end else if (natv_ready_i) begin
          mst_ready_o = grant_q;
          mst_rdata_o = natv_rdata_i;
          state_d     = IDLE;
          grant_d     = '0;
        end else if (tmo_fire) begin
          mst_ready_o = grant_q;
          mst_rdata_o = NATV_TIMEOUT_RDATA;
          state_d     = IDLE;
          grant_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_MST - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

endmodule
